// File: rtl/bram_fifo_pkg.sv
// ---------------------------------------------------------------------------
// bram_fifo_pkg
// Shared defaults and types for the block-RAM backed FWFT FIFO controller.
//   DW_DEF    : default data width
//   AW_DEF    : default RAM address width
//   DEPTH_DEF : RAM entries for the default address width
//   CNT_W_DEF : occupancy counter width (must hold DEPTH+1)
//   port_op_e : which client owns the single RAM port this cycle
// ---------------------------------------------------------------------------
package bram_fifo_pkg;

  localparam int DW_DEF    = 8;
  localparam int AW_DEF    = 4;
  localparam int DEPTH_DEF = 2 ** AW_DEF;
  localparam int CNT_W_DEF = AW_DEF + 1;

  // Owner of the shared RAM address bus in the current cycle.
  typedef enum logic {
    PORT_WRITE = 1'b0,
    PORT_FETCH = 1'b1
  } port_op_e;

  // Number of RAM entries addressed by an aw-bit pointer.
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage : bram_fifo_pkg

// File: rtl/bram_fifo_if.sv
// ---------------------------------------------------------------------------
// bram_fifo_if
// Write and read handshakes of the FIFO, bundled for port connection.
//   wr_valid/wr_ready/wr_data : producer side, word moves on valid && ready
//   rd_valid/rd_ready/rd_data : consumer side, word moves on valid && ready
// Modports:
//   slave  : the FIFO controller
//   master : the producer/consumer environment
// ---------------------------------------------------------------------------
interface bram_fifo_if
  import bram_fifo_pkg::*;
#(
  parameter int DW = DW_DEF
) ();

  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

endinterface : bram_fifo_if

// File: rtl/bram_fifo_outbuf.sv
// ---------------------------------------------------------------------------
// bram_fifo_outbuf
// Read-latency hiding stage: tracks the fetch in flight and captures the RAM
// output into a one-entry holding register that drives the read port.
//   clk, rst  : clock, asynchronous active-high reset
//   fetch     : a RAM read is issued this cycle
//   bram_dout : registered RAM data, meaningful the cycle after a fetch
//   rd_ready  : consumer accepts the held word
//   inflight  : a fetch was issued last cycle, its data is on bram_dout
//   out_valid : holding register contains the head-of-FIFO word
//   out_data  : holding register contents
// ---------------------------------------------------------------------------
module bram_fifo_outbuf
  import bram_fifo_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch,
  input  logic [DW-1:0] bram_dout,
  input  logic          rd_ready,
  output logic          inflight,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  logic          inflight_d,  inflight_q;
  logic          out_valid_d, out_valid_q;
  logic [DW-1:0] out_reg_d,   out_reg_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    inflight_d  = fetch;
    out_valid_d = out_valid_q;
    out_reg_d   = out_reg_q;
    if (inflight_q) begin
      // The fetch rule only lets data land into an empty or draining register,
      // so capturing unconditionally never overwrites an unread word.
      out_reg_d   = bram_dout;
      out_valid_d = 1'b1;
    end else if (out_valid_q && rd_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_reg_q   <= '0;
    end else begin
      inflight_q  <= inflight_d;
      out_valid_q <= out_valid_d;
      out_reg_q   <= out_reg_d;
    end
  end

  assign inflight  = inflight_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_reg_q;

endmodule : bram_fifo_outbuf

// File: rtl/syn_bram.sv
// ---------------------------------------------------------------------------
// syn_bram
// Single-port synchronous block RAM with a registered read port.
//   clk  : clock
//   we   : write enable, din stored at addr on the rising edge
//   addr : shared read/write address
//   din  : write data
//   dout : data at addr, registered (valid one cycle after addr is presented)
// ---------------------------------------------------------------------------
module syn_bram #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // NOTE: the storage array has no reset so it maps onto block RAM; the
  // controller never reads a location before writing it.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule : syn_bram

// File: rtl/bram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// bram_fifo_ctrl
// First-word-fall-through FIFO built on a single-port synchronous block RAM.
// Arbitrates the one RAM port between writes and read prefetches (prefetch
// wins) and hides the RAM read latency with bram_fifo_outbuf.
//   clk, rst  : clock, asynchronous active-high reset
//   fifo      : write/read handshakes (bram_fifo_if.slave)
//   count     : total occupancy = RAM entries + fetch in flight + held word
//   bram_we   : RAM write enable
//   bram_addr : RAM address (read pointer on fetch, write pointer otherwise)
//   bram_din  : RAM write data
//   bram_dout : RAM registered read data
// ---------------------------------------------------------------------------
module bram_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  bram_fifo_if.slave    fifo,
  output logic [AW:0]   count,
  output logic          bram_we,
  output logic [AW-1:0] bram_addr,
  output logic [DW-1:0] bram_din,
  input  logic [DW-1:0] bram_dout
);

  localparam int         DEPTH     = depth_of(AW);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_d,  wr_ptr_q;
  logic [AW-1:0] rd_ptr_d,  rd_ptr_q;
  logic [AW:0]   mem_cnt_d, mem_cnt_q;

  logic          fetch;
  logic          wr_ready_int;
  logic          wr_fire;
  logic          inflight;
  logic          out_valid;
  logic [DW-1:0] out_data;
  port_op_e      port_op;

  // Port arbitration. A fetch is issued whenever the RAM holds a word, no
  // fetch is already in flight, and the holding register will be free when
  // the data lands. Writes take the port only when no fetch wants it.
  always_comb begin
    fetch        = (mem_cnt_q != '0) && !inflight && (!out_valid || fifo.rd_ready);
    wr_ready_int = !rst && (mem_cnt_q != DEPTH_CNT) && !fetch;
    wr_fire      = fifo.wr_valid && wr_ready_int;
    port_op      = fetch ? PORT_FETCH : PORT_WRITE;
  end

  assign fifo.wr_ready = wr_ready_int;

  assign bram_we   = wr_fire;
  assign bram_addr = (port_op == PORT_FETCH) ? rd_ptr_q : wr_ptr_q;
  assign bram_din  = fifo.wr_data;

  // Pointer and RAM occupancy update. wr_fire and fetch never coincide, so
  // mem_cnt moves by at most one per cycle.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    mem_cnt_d = mem_cnt_q;
    if (wr_fire) begin
      wr_ptr_d  = wr_ptr_q + AW'(1);
      mem_cnt_d = mem_cnt_q + (AW+1)'(1);
    end
    if (fetch) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      mem_cnt_d = mem_cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_cnt_q <= mem_cnt_d;
    end
  end

  bram_fifo_outbuf #(
    .DW (DW)
  ) u_outbuf (
    .clk       (clk),
    .rst       (rst),
    .fetch     (fetch),
    .bram_dout (bram_dout),
    .rd_ready  (fifo.rd_ready),
    .inflight  (inflight),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  assign fifo.rd_valid = out_valid;
  assign fifo.rd_data  = out_data;

  // Purely state-derived: no combinational path from any input.
  assign count = mem_cnt_q + (AW+1)'(inflight) + (AW+1)'(out_valid);

  // A fetch is only issued into an empty holding register, so a fetch in
  // flight and a held word never coexist; occupancy tops out at DEPTH+1.
  a_no_inflight_while_held : assert property (
    @(posedge clk) disable iff (rst) !(inflight && out_valid)
  );
  a_count_bound : assert property (
    @(posedge clk) disable iff (rst) count <= DEPTH_CNT + (AW+1)'(1)
  );

endmodule : bram_fifo_ctrl

// File: tb/tb_bram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bram_fifo_ctrl
// Self-checking bench for bram_fifo_ctrl with a syn_bram behind it.
// Accepted words are pushed into a reference queue; a negedge monitor pops
// and compares on every read handshake and checks occupancy, RAM write
// traffic and backpressure stability against that queue.
// ---------------------------------------------------------------------------
module tb_bram_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW:0]   count;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout;

  always #5 clk = ~clk;

  bram_fifo_if #(.DW(DW)) fifo_if ();

  bram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo      (fifo_if),
    .count     (count),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .bram_dout (bram_dout)
  );

  syn_bram #(.DW(DW), .AW(AW)) u_ram (
    .clk  (clk),
    .we   (bram_we),
    .addr (bram_addr),
    .din  (bram_din),
    .dout (bram_dout)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: the FIFO contents as a queue, plus the next RAM write
  // address (words accepted since reset, modulo DEPTH).
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_wr_addr = '0;
  logic          prev_stall  = 1'b0;
  logic [DW-1:0] prev_data   = '0;
  logic [DW-1:0] exp_word;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_wr_addr = '0;
      prev_stall  = 1'b0;
      check("rst_rd_valid", 32'(fifo_if.rd_valid), 0);
      check("rst_count",    32'(count), 0);
      check("rst_wr_ready", 32'(fifo_if.wr_ready), 0);
      check("rst_bram_we",  32'(bram_we), 0);
    end else begin
      check("count", 32'(count), 32'(exp_q.size()));
      if (exp_q.size() == DEPTH + 1) check("full_wr_ready", 32'(fifo_if.wr_ready), 0);
      check("bram_we", 32'(bram_we), 32'(fifo_if.wr_valid && fifo_if.wr_ready));
      if (bram_we) begin
        check("bram_addr_wr", 32'(bram_addr), 32'(exp_wr_addr));
        check("bram_din", 32'(bram_din), 32'(fifo_if.wr_data));
      end
      if (prev_stall) begin
        check("hold_valid", 32'(fifo_if.rd_valid), 1);
        check("hold_data",  32'(fifo_if.rd_data), 32'(prev_data));
      end
      if (fifo_if.rd_valid && fifo_if.rd_ready) begin
        if (exp_q.size() == 0) begin
          check("rd_on_empty", 32'(fifo_if.rd_valid), 0);
        end else begin
          exp_word = exp_q.pop_front();
          check("rd_data", 32'(fifo_if.rd_data), 32'(exp_word));
        end
      end
      if (fifo_if.wr_valid && fifo_if.wr_ready) begin
        exp_q.push_back(fifo_if.wr_data);
        exp_wr_addr = exp_wr_addr + 1'b1;
      end
      prev_stall = fifo_if.rd_valid && !fifo_if.rd_ready;
      prev_data  = fifo_if.rd_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fifo_if.wr_valid = 1'b0;
    fifo_if.rd_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Offer one word and hold it until accepted; returns the acceptance cycle.
  task automatic write_word(input logic [DW-1:0] d, output int acc_cyc);
    int waited;
    waited = 0;
    fifo_if.wr_valid = 1'b1;
    fifo_if.wr_data  = d;
    @(negedge clk);
    while (!fifo_if.wr_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!fifo_if.wr_ready) check("wr_accept_timeout", 32'(fifo_if.wr_ready), 1);
    acc_cyc = cyc;
    tick();
    fifo_if.wr_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int waited;
    waited = 0;
    @(negedge clk);
    while ((count != 0 || fifo_if.rd_valid) && waited < 500) begin
      waited++;
      @(negedge clk);
    end
    check("drain_count", 32'(count), 0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_aa, acc_tmp, first_rd;
    int waited;
    logic accepted;

    fifo_if.wr_valid = 1'b0;
    fifo_if.wr_data  = '0;
    fifo_if.rd_ready = 1'b0;
    tick();

    // AA, BB, CC from empty with consumer ready; check first-word latency.
    do_reset();
    @(negedge clk);
    check("wr_ready_after_rst", 32'(fifo_if.wr_ready), 1);
    tick();
    fifo_if.rd_ready = 1'b1;
    first_rd = -1;
    acc_aa   = 0;
    fork
      begin
        write_word(8'hAA, acc_aa);
        write_word(8'hBB, acc_tmp);
        write_word(8'hCC, acc_tmp);
      end
      begin
        waited = 0;
        @(negedge clk);
        while (!fifo_if.rd_valid && waited < 40) begin
          waited++;
          @(negedge clk);
        end
        if (fifo_if.rd_valid) first_rd = cyc;
      end
    join
    check("first_rd_latency", 32'(first_rd - acc_aa), 3);
    wait_empty();

    // Write held during a fetch cycle is stalled, then lands at wr_ptr.
    do_reset();
    fifo_if.wr_valid = 1'b1;
    fifo_if.wr_data  = 8'h11;
    @(negedge clk);
    check("wf_ready_c0", 32'(fifo_if.wr_ready), 1);
    check("wf_addr_c0",  32'(bram_addr), 0);
    tick();
    fifo_if.wr_data = 8'h22;
    @(negedge clk);
    check("wf_ready_fetch", 32'(fifo_if.wr_ready), 0);
    check("wf_we_fetch",    32'(bram_we), 0);
    check("wf_addr_fetch",  32'(bram_addr), 0);
    tick();
    @(negedge clk);
    check("wf_ready_c2", 32'(fifo_if.wr_ready), 1);
    check("wf_we_c2",    32'(bram_we), 1);
    check("wf_addr_c2",  32'(bram_addr), 1);
    tick();
    fifo_if.wr_valid = 1'b0;
    fifo_if.rd_ready = 1'b1;
    wait_empty();

    // Fill to DEPTH+1 with the consumer stalled, then drain in order.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) write_word(DW'(i), acc_tmp);
    @(negedge clk);
    check("full_ready", 32'(fifo_if.wr_ready), 0);
    check("full_count", 32'(count), DEPTH + 1);
    tick();
    fifo_if.wr_valid = 1'b1;
    fifo_if.wr_data  = 8'hFF;
    repeat (4) begin
      @(negedge clk);
      check("full_ignore", 32'(fifo_if.wr_ready), 0);
    end
    tick();
    fifo_if.wr_valid = 1'b0;
    fifo_if.rd_ready = 1'b1;
    wait_empty();

    // Streaming 40 words through: pointers wrap twice.
    do_reset();
    fifo_if.rd_ready = 1'b1;
    for (int i = 0; i < 40; i++) write_word(DW'(i), acc_tmp);
    wait_empty();

    // Backpressure: 5A held for 5 cycles, 6B appears 2 cycles after release.
    do_reset();
    write_word(8'h5A, acc_tmp);
    write_word(8'h6B, acc_tmp);
    waited = 0;
    @(negedge clk);
    while (!fifo_if.rd_valid && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    check("bp_data_first", 32'(fifo_if.rd_data), 32'h5A);
    repeat (5) begin
      @(negedge clk);
      check("bp_data_hold", 32'(fifo_if.rd_data), 32'h5A);
      check("bp_no_fetch",  32'(bram_addr), 2);
    end
    tick();
    fifo_if.rd_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(fifo_if.rd_valid), 1);
    @(negedge clk);
    check("bp_gap_valid", 32'(fifo_if.rd_valid), 0);
    @(negedge clk);
    check("bp_next_valid", 32'(fifo_if.rd_valid), 1);
    check("bp_next_data",  32'(fifo_if.rd_data), 32'h6B);
    tick();
    wait_empty();

    // Reset while a fetch of 77 is in flight; 77 must never surface.
    do_reset();
    fifo_if.rd_ready = 1'b1;
    write_word(8'h77, acc_tmp);
    tick();
    rst = 1'b1;
    #1;
    check("midrst_rd_valid", 32'(fifo_if.rd_valid), 0);
    check("midrst_count",    32'(count), 0);
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_wr_ready", 32'(fifo_if.wr_ready), 1);
    tick();
    write_word(8'h3C, acc_tmp);
    waited = 0;
    @(negedge clk);
    while (!fifo_if.rd_valid && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    check("midrst_readback", 32'(fifo_if.rd_data), 32'h3C);
    tick();
    wait_empty();

    // Randomized traffic: filling phase then draining-biased phase.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (!fifo_if.wr_valid && $urandom_range(0, 99) < 60) begin
        fifo_if.wr_valid = 1'b1;
        fifo_if.wr_data  = DW'($urandom);
      end
      fifo_if.rd_ready = ($urandom_range(0, 99) < ((c < 400) ? 30 : 80));
      @(negedge clk);
      accepted = fifo_if.wr_valid && fifo_if.wr_ready;
      tick();
      if (accepted) fifo_if.wr_valid = 1'b0;
    end
    fifo_if.wr_valid = 1'b0;
    fifo_if.rd_ready = 1'b1;
    wait_empty();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bram_fifo_ctrl

// File: doc/bram_fifo_ctrl.md
Name: bram_fifo_ctrl

Overview:
Controller that turns the single-port synchronous block RAM (syn_bram: we, addr, din, registered dout, 1-cycle read latency) into a first-word-fall-through FIFO.
- Sits directly in front of the RAM: drives we/addr/din and consumes dout.
- Exposes valid/ready handshakes on the write and read sides.
- Arbitrates the single RAM port between writes and read prefetches, and hides read latency with a one-entry output holding register.

Parameters:
DW, 8, data width; must match RAM din/dout width.
AW, 4, RAM address width; DEPTH = 2**AW RAM entries (16).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous reset, active-high; clears all control state immediately.
wr_valid  input  1  write request.
wr_ready  output  1  write accepted this cycle when wr_valid && wr_ready.
wr_data  input  DW  write data.
rd_valid  output  1  rd_data holds valid head-of-FIFO word.
rd_ready  input  1  consumer takes word when rd_valid && rd_ready.
rd_data  output  DW  head-of-FIFO word.
count  output  AW+1  total occupancy: RAM entries + in-flight fetch + holding register (0..DEPTH+1).
bram_we  output  1  RAM write enable.
bram_addr  output  AW  RAM address.
bram_din  output  DW  RAM write data.
bram_dout  input  DW  RAM registered read data, valid the cycle after a fetch.

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - wr_ptr, rd_ptr, mem_cnt, inflight, out_valid, count all 0.
  - rd_valid=0, rd_data=0.
  - bram_we=0 while rst high; wr_ready forced 0 while rst high.
  - RAM contents are not cleared.
- Internal state:
  - wr_ptr, rd_ptr (AW bits, wrap modulo DEPTH).
  - mem_cnt (AW+1 bits, entries in RAM).
  - inflight (fetch issued last cycle).
  - out_valid/out_reg (holding register).
- Fetch decision, combinational:
  - fetch = mem_cnt!=0 && !inflight && (!out_valid || rd_ready).
  - Fetch has priority over write for the single port.
- Write handshake:
  - wr_ready = !rst && mem_cnt!=DEPTH && !fetch.
  - wr_fire = wr_valid && wr_ready.
- RAM drive:
  - bram_we = wr_fire.
  - bram_addr = fetch ? rd_ptr : wr_ptr.
  - bram_din = wr_data.
- On wr_fire: wr_ptr+1, mem_cnt+1.
- On fetch: rd_ptr+1, mem_cnt-1, inflight<=1; otherwise inflight<=0. wr_fire and fetch are mutually exclusive.
- Holding register:
  - When inflight=1, out_reg<=bram_dout and out_valid<=1.
  - Else, if rd_valid && rd_ready, out_valid<=0.
  - The fetch rule guarantees the register is empty or being drained in the cycle the data lands.
- rd_valid = out_valid; rd_data = out_reg.
- count = mem_cnt + inflight + out_valid. count is registered-equivalent, derived from state, with no combinational path from inputs.
- Latency: word accepted at cycle 0 into an empty FIFO -> fetch in cycle 1 -> dout cycle 2 -> rd_valid high cycle 3.
- Throughput: at most one RAM access per cycle. Sustained streaming alternates fetch/write; a read-side word is available every 2 cycles.
- Full: mem_cnt==DEPTH -> wr_ready=0. wr_valid is ignored and no pointer moves.
- Empty: mem_cnt==0 -> no fetch. rd_valid stays low until a word reaches the holding register.
- Wrap-around: pointers roll DEPTH-1 -> 0 with no bubble. Ordering is preserved across wrap.
- Backpressure: rd_valid && !rd_ready holds rd_data stable and blocks further fetches.
- Write while fetch: wr_ready=0 that cycle. The writer must hold wr_valid/wr_data until accepted.
- Reset mid-operation:
  - State clears asynchronously; any in-flight dout is discarded.
  - After rst deasserts, the FIFO is empty and wr_ready=1 on the first cycle.

Decomposition:
- Package bram_fifo_pkg holds default DW=8, AW=4, localparam DEPTH=2**AW, and count width AW+1.
- One natural sub-module: bram_fifo_outbuf, holding inflight, out_valid and out_reg, with the capture/drain logic.
- Pointer, count and arbitration logic stays in the top.
- Bench instantiates syn_bram alongside the controller.

Test Plan:
- Write AA, BB, CC on consecutive cycles from empty, rd_ready=1 -> rd_data sequence AA, BB, CC; first rd_valid 3 cycles after AA accepted; count returns to 0.
- Write 17 words 00..10 with rd_ready=0 -> wr_ready drops after the 17th acceptance, count=17 (16 RAM + 1 held); extra wr_valid is ignored; draining yields 00..10 in order.
- Stream 40 words 00..27 with rd_ready=1 and wr_valid=1 -> pointers wrap twice; output exactly 00..27 in order; wr_ready low in every fetch cycle.
- Hold rd_ready=0 for 5 cycles with rd_valid=1 (data 5A) -> rd_data stays 5A; bram_addr shows no fetch; on rd_ready=1, next word appears 2 cycles later.
- Assert rst one cycle after a fetch of 77 -> rd_valid=0 and count=0 immediately; 77 never appears; a subsequent write of 3C reads back 3C.
- Hold wr_valid=1 during the cycle fetch=1 -> wr_ready=0, bram_we=0; write of the held data completes the next cycle with correct bram_addr=wr_ptr.
